// File: rtl/ascon_drv_pkg.sv
// rtl/ascon_drv_pkg.sv - state encoding and sizing helper shared by the Ascon serial driver
package ascon_drv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CORE_RST,
      S_SHIFT,
      S_SETTLE,
      S_START,
      S_WAIT_RDY,
      S_CAPTURE,
      S_DONE
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ascon_piso.sv
// rtl/ascon_piso.sv - parallel-load MSB-first shifter, zero fill once WIDTH bits are out
module ascon_piso #(
   parameter int WIDTH = 32,
   parameter int LEN   = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             sout
);

   logic [LEN-1:0] sr;

   // Field is left-aligned so the zeros shifted in behind it become the tail fill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= LEN'(data) << (LEN - WIDTH);
      end else if (shift) begin
         sr <= {sr[LEN-2:0], 1'b0};
      end
   end

   assign sout = shift & sr[LEN-1];

endmodule

// File: rtl/ascon_serial_driver.sv
// rtl/ascon_serial_driver.sv - drives one job into the bit-serial Ascon wrapper and collects data/tag
// ASCON_DRV_TIMEOUT_EN: bound WAIT_RDY to TIMEOUT cycles and flag res_err on expiry.
module ascon_serial_driver
   import ascon_drv_pkg::*;
#(
   parameter int K       = 128,
   parameter int L       = 32,
   parameter int Y       = 32,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [K-1:0] job_key,
   input  logic [127:0] job_nonce,
   input  logic [L-1:0] job_ad,
   input  logic [Y-1:0] job_data,
   input  logic         job_decrypt,
   output logic         asc_rst,
   output logic         keyxSI,
   output logic         noncexSI,
   output logic         associated_dataxSI,
   output logic         input_dataxSI,
   output logic         ascon_startxSI,
   output logic         decrypt,
   input  logic         output_dataxSO,
   input  logic         tagxSO,
   input  logic         ascon_readyxSO,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [Y-1:0] res_data,
   output logic [127:0] res_tag,
   output logic         res_err
);

   localparam int N  = max2(max2(K, 128), max2(L, Y));
   localparam int W  = max2(Y, 128);
   localparam int CW = $clog2(max2(max2(N, W), TIMEOUT) + 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            rdy_q;
   logic            accept;
   logic            shifting;
   logic            sample;
   logic            count_en;
   logic            timeout;
   logic            dec_q;
   logic [Y-1:0]    data_sr;
   logic [127:0]    tag_sr;

   assign accept   = (state == S_IDLE) && job_valid;
   assign shifting = (state == S_SHIFT);
   // Wrapper output is registered once, so a bit is valid the cycle after ready was seen high.
   assign sample   = (state == S_CAPTURE) && rdy_q;
   assign count_en = shifting || (state == S_WAIT_RDY) || sample;

   ascon_piso #(.WIDTH(K),   .LEN(N)) u_key   (.clk(clk), .rst(rst), .load(accept), .shift(shifting), .data(job_key),   .sout(keyxSI));
   ascon_piso #(.WIDTH(128), .LEN(N)) u_nonce (.clk(clk), .rst(rst), .load(accept), .shift(shifting), .data(job_nonce), .sout(noncexSI));
   ascon_piso #(.WIDTH(L),   .LEN(N)) u_ad    (.clk(clk), .rst(rst), .load(accept), .shift(shifting), .data(job_ad),    .sout(associated_dataxSI));
   ascon_piso #(.WIDTH(Y),   .LEN(N)) u_data  (.clk(clk), .rst(rst), .load(accept), .shift(shifting), .data(job_data),  .sout(input_dataxSI));

`ifdef ASCON_DRV_TIMEOUT_EN
   logic err_q;

   assign timeout = (state == S_WAIT_RDY) && !ascon_readyxSO && (cnt == CW'(TIMEOUT - 1));
   assign res_err = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign res_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      job_ready      = 1'b0;
      asc_rst        = 1'b0;
      ascon_startxSI = 1'b0;
      res_valid      = 1'b0;
      case (state)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) state_nx = S_CORE_RST;
         end
         S_CORE_RST: begin
            asc_rst  = 1'b1;
            state_nx = S_SHIFT;
         end
         S_SHIFT:    if (cnt == CW'(N - 1)) state_nx = S_SETTLE;
         S_SETTLE:   state_nx = S_START;
         S_START: begin
            ascon_startxSI = 1'b1;
            state_nx       = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (ascon_readyxSO)  state_nx = S_CAPTURE;
            else if (timeout)    state_nx = S_DONE;
         end
         S_CAPTURE:  if (sample && (cnt == CW'(W - 1))) state_nx = S_DONE;
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = S_IDLE;
         end
         default:    state_nx = S_IDLE;
      endcase
   end

   // Counter restarts on every state change and saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= ascon_readyxSO;
         if (state_nx != state) begin
            cnt <= '0;
         end else if (count_en && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_sr <= '0;
         tag_sr  <= '0;
         dec_q   <= 1'b0;
      end else if (accept) begin
         data_sr <= '0;
         tag_sr  <= '0;
         dec_q   <= job_decrypt;
      end else if (sample) begin
         if (cnt < CW'(Y))   data_sr <= {output_dataxSO, data_sr[Y-1:1]};
         if (cnt < CW'(128)) tag_sr  <= {tagxSO, tag_sr[127:1]};
      end
   end

   assign decrypt  = dec_q;
   assign res_data = data_sr;
   assign res_tag  = tag_sr;

endmodule
